id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Registered RV32/RV64 decode stage with valid/ready handshakes on both sides.
//  Sits between if_id and exe and replaces the combinational decode + id_exe register pair.
//  Decodes the OP-IMM, OP, LUI and AUIPC opcodes and forwards one writeback port into the operands.
//  Holds one decoded instruction and stalls cleanly under exe back-pressure.
// PARAMETERS
//  XLEN        32   datapath width in bits; legal values are 32 and 64. Sets op1/op2 and forwarding width.
//  ADDR_WIDTH  32   instruction address width in bits; must be <= XLEN.
//  RADDR_WIDTH 5    register index width in bits.
// PORTS
//  clk_i         in   1            clock; all state updates on the rising edge
//  rst_i         in   1            synchronous reset, active high
//  flush_i       in   1            discard the held instruction and any instruction being accepted this cycle
//  in_valid_i    in   1            if_id presents an instruction
//  in_ready_o    out  1            stage can accept an instruction this cycle
//  inst_addr_i   in   ADDR_WIDTH   PC of the presented instruction
//  inst_i        in   32           presented instruction
//  reg1_raddr_o  out  RADDR_WIDTH  regfile read port 1 index (rs1); combinational from inst_i
//  reg2_raddr_o  out  RADDR_WIDTH  regfile read port 2 index (rs2); combinational from inst_i
//  reg1_re_o     out  1            read enable for port 1
//  reg2_re_o     out  1            read enable for port 2
//  reg1_rdata_i  in   XLEN         regfile read data, port 1
//  reg2_rdata_i  in   XLEN         regfile read data, port 2
//  fwd_we_i      in   1            writeback is writing this cycle
//  fwd_waddr_i   in   RADDR_WIDTH  writeback destination register
//  fwd_wdata_i   in   XLEN         writeback data
//  out_valid_o   out  1            registered decoded instruction is valid
//  out_ready_i   in   1            exe accepts the output this cycle
//  inst_o        out  32           registered instruction, or NOP (32'h0000_0013) if illegal
//  inst_addr_o   out  ADDR_WIDTH   registered PC
//  op1_o         out  XLEN         operand 1
//  op2_o         out  XLEN         operand 2
//  reg_we_o      out  1            destination write enable
//  reg_waddr_o   out  RADDR_WIDTH  destination register
//  illegal_o     out  1            the held instruction had an unsupported opcode
// BEHAVIOUR
//  Reset values (next edge with rst_i=1):
//   - out_valid_o=0, inst_o=NOP, reg_we_o=0, illegal_o=0.
//   - inst_addr_o, op1_o, op2_o and reg_waddr_o are all 0.
//   - rst_i has priority over flush_i and over the handshake; reset mid-stall drops the held instruction.
//  Handshake:
//   - in_ready_o = !out_valid_o | out_ready_i (combinational; 0 while rst_i=1).
//   - accept = in_valid_i & in_ready_o. On accept, the decode result is registered and out_valid_o=1 next cycle.
//   - If out_ready_i=1 with no accept, out_valid_o=0 next cycle.
//   - While out_valid_o=1 and out_ready_i=0, every output holds stable.
//   - Latency is 1 cycle. Throughput is 1 instruction per cycle when out_ready_i is held at 1.
//  Flush:
//   - flush_i=1 forces out_valid_o=0 next cycle and suppresses any accept in the same cycle.
//   - in_ready_o is not gated by flush_i.
//  Read enables and indices are driven from inst_i whenever in_valid_i=1. Otherwise they are 0.
//  Decode by opcode inst_i[6:0]:
//   - OP-IMM 0010011: re1=1, re2=0, op1=rs1 value, op2=sext(inst[31:20]).
//     For SLLI/SRLI/SRAI (funct3 001/101), op2 = zext(inst[24+log2(XLEN)-5:20]) with bit 30 kept in inst_o.
//   - OP 0110011: re1=re2=1, op1=rs1 value, op2=rs2 value.
//   - LUI 0110111: re1=re2=0, op1=0, op2=sext({inst[31:12],12'b0}) to XLEN.
//   - AUIPC 0010111: op1=zext(inst_addr_i), op2 as for LUI.
//   - Any other opcode: inst_o=NOP, op1=op2=0, reg_we_o=0, illegal_o=1. Still handshaked as a valid output.
//  Writeback:
//   - reg_waddr_o=inst[11:7].
//   - reg_we_o=1 only for a legal opcode with rd!=0; rd=0 gives reg_we_o=0.
//  Operand source, per port, evaluated at accept:
//   - port disabled or index 0 -> 0.
//   - else fwd_we_i & fwd_waddr_i==index -> fwd_wdata_i.
//   - else regfile data.
//  Both ports may forward from fwd_wdata_i in the same cycle.
// TESTING
//  1. Reset, then ADDI x1,x2,-1 (32'hFFF1_0093) with x2=5, out_ready_i=1 -> next cycle out_valid_o=1, op1=5, op2=32'hFFFF_FFFF, reg_we=1, waddr=1.
//  2. Back-to-back: 3 instructions with out_ready_i=0 in cycle 2 -> in_ready_o=0 that cycle, outputs hold, no instruction lost or duplicated.
//  3. ADD x3,x1,x1 with fwd_we=1, waddr=1, wdata=0xA5 and regfile=0 -> op1=op2=0xA5. Same test with fwd_waddr=0 -> op1=op2=0.
//  4. LUI x5,0x80000 with XLEN=64 -> op2=64'hFFFF_FFFF_8000_0000. AUIPC at PC=0x100 -> op1=0x100.
//  5. Opcode 7'b1111111 -> out_valid_o=1, illegal_o=1, inst_o=NOP, reg_we=0. ADDI x0 -> reg_we=0.
//  6. flush_i and rst_i asserted while stalled and while accepting -> out_valid_o=0 next cycle. Reset outputs as specified above.

Source files
------------

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered RV32/RV64 decode stage between if_id and exe.
// Decodes OP-IMM, OP, LUI and AUIPC and builds operands, forwarding one
// writeback port. It holds one decoded instruction, with valid/ready on both sides.
// Ports:
//   clk_i, rst_i (sync, active high), flush_i
//   in_valid_i / in_ready_o, inst_addr_i, inst_i          : upstream handshake
//   reg{1,2}_raddr_o, reg{1,2}_re_o, reg{1,2}_rdata_i     : regfile read ports
//   fwd_we_i, fwd_waddr_i, fwd_wdata_i                    : writeback forward
//   out_valid_o / out_ready_i, inst_o, inst_addr_o,
//   op1_o, op2_o, reg_we_o, reg_waddr_o, illegal_o        : registered result
module id_stage_pipe #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned RADDR_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [ADDR_WIDTH-1:0]  inst_addr_i,
  input  logic [31:0]            inst_i,
  output logic [RADDR_WIDTH-1:0] reg1_raddr_o,
  output logic [RADDR_WIDTH-1:0] reg2_raddr_o,
  output logic                   reg1_re_o,
  output logic                   reg2_re_o,
  input  logic [XLEN-1:0]        reg1_rdata_i,
  input  logic [XLEN-1:0]        reg2_rdata_i,
  input  logic                   fwd_we_i,
  input  logic [RADDR_WIDTH-1:0] fwd_waddr_i,
  input  logic [XLEN-1:0]        fwd_wdata_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [31:0]            inst_o,
  output logic [ADDR_WIDTH-1:0]  inst_addr_o,
  output logic [XLEN-1:0]        op1_o,
  output logic [XLEN-1:0]        op2_o,
  output logic                   reg_we_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   illegal_o
);

  localparam int unsigned SHW       = (XLEN == 64) ? 6 : 5;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OPC_OPIMM = 7'b0010011;
  localparam logic [6:0]  OPC_OP    = 7'b0110011;
  localparam logic [6:0]  OPC_LUI   = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC = 7'b0010111;

  logic                   out_valid_q, out_valid_d;
  logic [31:0]            inst_q, inst_d;
  logic [ADDR_WIDTH-1:0]  inst_addr_q, inst_addr_d;
  logic [XLEN-1:0]        op1_q, op1_d, op2_q, op2_d;
  logic                   reg_we_q, reg_we_d;
  logic [RADDR_WIDTH-1:0] reg_waddr_q, reg_waddr_d;
  logic                   illegal_q, illegal_d;

  logic                   legal_c, re1_c, re2_c, use_pc_c, accept_c;
  logic [RADDR_WIDTH-1:0] rs1_c, rs2_c, rd_c;
  logic [XLEN-1:0]        imm_c, src1_c, src2_c;

  // Opcode decode: read enables, immediate and op1 source
  always_comb begin
    legal_c  = 1'b0;
    re1_c    = 1'b0;
    re2_c    = 1'b0;
    use_pc_c = 1'b0;
    imm_c    = '0;
    rs1_c    = RADDR_WIDTH'(inst_i[19:15]);
    rs2_c    = RADDR_WIDTH'(inst_i[24:20]);
    rd_c     = RADDR_WIDTH'(inst_i[11:7]);
    unique case (inst_i[6:0])
      OPC_OPIMM: begin
        legal_c = 1'b1;
        re1_c   = 1'b1;
        // Shifts take only the shamt field; bit 30 stays in inst_o for SRAI
        if (inst_i[13:12] == 2'b01) imm_c = XLEN'(inst_i[20 +: SHW]);
        else                        imm_c = XLEN'($signed(inst_i[31:20]));
      end
      OPC_OP: begin
        legal_c = 1'b1;
        re1_c   = 1'b1;
        re2_c   = 1'b1;
      end
      OPC_LUI: begin
        legal_c = 1'b1;
        imm_c   = XLEN'($signed({inst_i[31:12], 12'b0}));
      end
      OPC_AUIPC: begin
        legal_c  = 1'b1;
        use_pc_c = 1'b1;
        imm_c    = XLEN'($signed({inst_i[31:12], 12'b0}));
      end
      default: ;
    endcase
  end

  // Operand source per port: disabled/x0 -> 0, then forward, then regfile
  always_comb begin
    src1_c = '0;
    src2_c = '0;
    if (re1_c && (rs1_c != '0))
      src1_c = (fwd_we_i && (fwd_waddr_i == rs1_c)) ? fwd_wdata_i : reg1_rdata_i;
    if (re2_c && (rs2_c != '0))
      src2_c = (fwd_we_i && (fwd_waddr_i == rs2_c)) ? fwd_wdata_i : reg2_rdata_i;
  end

  assign reg1_re_o    = in_valid_i & re1_c;
  assign reg2_re_o    = in_valid_i & re2_c;
  assign reg1_raddr_o = in_valid_i ? rs1_c : '0;
  assign reg2_raddr_o = in_valid_i ? rs2_c : '0;

  assign in_ready_o = ~rst_i & (~out_valid_q | out_ready_i);
  assign accept_c   = in_valid_i & in_ready_o & ~flush_i;

  // Next-state: hold by default, load on accept, drain on downstream ready
  always_comb begin
    out_valid_d = out_valid_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    reg_we_d    = reg_we_q;
    reg_waddr_d = reg_waddr_q;
    illegal_d   = illegal_q;
    if (out_ready_i) out_valid_d = 1'b0;
    if (accept_c) begin
      out_valid_d = 1'b1;
      inst_d      = legal_c ? inst_i : NOP;
      inst_addr_d = inst_addr_i;
      op1_d       = use_pc_c ? XLEN'(inst_addr_i) : src1_c;
      op2_d       = re2_c ? src2_c : imm_c;
      reg_we_d    = legal_c & (rd_c != '0);
      reg_waddr_d = rd_c;
      illegal_d   = ~legal_c;
    end
    if (flush_i) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      inst_q      <= NOP;
      inst_addr_q <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign inst_o      = inst_q;
  assign inst_addr_o = inst_addr_q;
  assign op1_o       = op1_q;
  assign op2_o       = op2_q;
  assign reg_we_o    = reg_we_q;
  assign reg_waddr_o = reg_waddr_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Testbench for id_stage_pipe at XLEN=64: vector table plus scoreboard queue.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic        in_ready_o, reg1_re_o, reg2_re_o, out_valid_o, reg_we_o, illegal_o;
  logic [31:0] inst_addr_i = '0, inst_i = '0, inst_o, inst_addr_o;
  logic [4:0]  reg1_raddr_o, reg2_raddr_o, fwd_waddr_i = '0, reg_waddr_o;
  logic [63:0] reg1_rdata_i = '0, reg2_rdata_i = '0, fwd_wdata_i = '0, op1_o, op2_o;
  logic        fwd_we_i = 1'b0;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(64), .ADDR_WIDTH(32), .RADDR_WIDTH(5)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_addr_i(inst_addr_i), .inst_i(inst_i),
    .reg1_raddr_o(reg1_raddr_o), .reg2_raddr_o(reg2_raddr_o),
    .reg1_re_o(reg1_re_o), .reg2_re_o(reg2_re_o),
    .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
    .fwd_we_i(fwd_we_i), .fwd_waddr_i(fwd_waddr_i), .fwd_wdata_i(fwd_wdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .illegal_o(illegal_o)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [63:0] r1, r2;
    logic        fwe;
    logic [4:0]  fwa;
    logic [63:0] fwd;
    logic        re1, re2;
    logic [4:0]  ra1, ra2;
    logic [31:0] e_inst;
    logic [63:0] e_op1, e_op2;
    logic        e_we;
    logic [4:0]  e_wa;
    logic        e_ill;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];
  vec_t q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at posedge+1, check outputs and scoreboard at negedge
  task automatic cycle(input int idx, input logic v, input logic rdy,
                       input logic fl, input logic rs);
    vec_t r;
    logic expv, expr;
    r = '{default: '0};
    if (idx >= 0) r = tbl[idx];
    @(posedge clk); #1;
    inst_i = r.inst; inst_addr_i = r.pc;
    reg1_rdata_i = r.r1; reg2_rdata_i = r.r2;
    fwd_we_i = r.fwe; fwd_waddr_i = r.fwa; fwd_wdata_i = r.fwd;
    in_valid_i = v; out_ready_i = rdy; flush_i = fl; rst_i = rs;
    @(negedge clk);
    expv = (q.size() != 0);
    chk("out_valid", 64'(out_valid_o), 64'(expv));
    if (expv && out_valid_o) begin
      chk("inst_o", 64'(inst_o), 64'(q[0].e_inst));
      chk("inst_addr_o", 64'(inst_addr_o), 64'(q[0].pc));
      chk("op1_o", op1_o, q[0].e_op1);
      chk("op2_o", op2_o, q[0].e_op2);
      chk("reg_we_o", 64'(reg_we_o), 64'(q[0].e_we));
      chk("reg_waddr_o", 64'(reg_waddr_o), 64'(q[0].e_wa));
      chk("illegal_o", 64'(illegal_o), 64'(q[0].e_ill));
    end
    expr = !rs && (!expv || rdy);
    chk("in_ready", 64'(in_ready_o), 64'(expr));
    chk("reg1_re", 64'(reg1_re_o), 64'(v & r.re1));
    chk("reg2_re", 64'(reg2_re_o), 64'(v & r.re2));
    chk("reg1_raddr", 64'(reg1_raddr_o), v ? 64'(r.ra1) : 64'd0);
    chk("reg2_raddr", 64'(reg2_raddr_o), v ? 64'(r.ra2) : 64'd0);
    if (expv && rdy) void'(q.pop_front());
    if (rs || fl) q.delete();
    else if (v && expr) q.push_back(r);
  endtask

  task automatic check_reset();
    chk("rst out_valid", 64'(out_valid_o), 64'd0);
    chk("rst inst_o", 64'(inst_o), 64'h13);
    chk("rst inst_addr", 64'(inst_addr_o), 64'd0);
    chk("rst op1", op1_o, 64'd0);
    chk("rst op2", op2_o, 64'd0);
    chk("rst reg_we", 64'(reg_we_o), 64'd0);
    chk("rst waddr", 64'(reg_waddr_o), 64'd0);
    chk("rst illegal", 64'(illegal_o), 64'd0);
  endtask

  initial begin
    // inst, pc, r1, r2, fwe, fwa, fwd, re1, re2, ra1, ra2, e_inst, e_op1, e_op2, e_we, e_wa, e_ill
    tbl[0]  = '{32'hFFF1_0093, 32'h1000, 64'd5, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 5'd2, 5'd31,
                32'hFFF1_0093, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd1, 1'b0};       // ADDI x1,x2,-1
    tbl[1]  = '{32'h0010_81B3, 32'h1004, 64'd0, 64'd0, 1'b1, 5'd1, 64'hA5, 1'b1, 1'b1, 5'd1, 5'd1,
                32'h0010_81B3, 64'hA5, 64'hA5, 1'b1, 5'd3, 1'b0};                       // ADD fwd both
    tbl[2]  = '{32'h0010_81B3, 32'h1008, 64'd0, 64'd0, 1'b1, 5'd0, 64'hA5, 1'b1, 1'b1, 5'd1, 5'd1,
                32'h0010_81B3, 64'd0, 64'd0, 1'b1, 5'd3, 1'b0};                         // fwd to x0
    tbl[3]  = '{32'h0010_81B3, 32'h100C, 64'h11, 64'h22, 1'b1, 5'd2, 64'hEE, 1'b1, 1'b1, 5'd1, 5'd1,
                32'h0010_81B3, 64'h11, 64'h22, 1'b1, 5'd3, 1'b0};                       // fwd miss
    tbl[4]  = '{32'h8000_02B7, 32'h1010, 64'h77, 64'h77, 1'b1, 5'd0, 64'hEE, 1'b0, 1'b0, 5'd0, 5'd0,
                32'h8000_02B7, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b1, 5'd5, 1'b0};      // LUI x5,0x80000
    tbl[5]  = '{32'h0000_1317, 32'h0100, 64'h77, 64'h77, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd0, 5'd0,
                32'h0000_1317, 64'h100, 64'h1000, 1'b1, 5'd6, 1'b0};                    // AUIPC x6,1
    tbl[6]  = '{32'h1234_5FFF, 32'h1018, 64'h33, 64'h44, 1'b1, 5'd8, 64'hEE, 1'b0, 1'b0, 5'd8, 5'd3,
                32'h0000_0013, 64'd0, 64'd0, 1'b0, 5'd31, 1'b1};                        // illegal
    tbl[7]  = '{32'h0050_8013, 32'h101C, 64'd9, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 5'd1, 5'd5,
                32'h0050_8013, 64'd9, 64'd5, 1'b0, 5'd0, 1'b0};                         // ADDI x0
    tbl[8]  = '{32'h4214_5393, 32'h1020, 64'hDEAD, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 5'd8, 5'd1,
                32'h4214_5393, 64'hDEAD, 64'h21, 1'b1, 5'd7, 1'b0};                     // SRAI x7,x8,33
    tbl[9]  = '{32'h0031_0233, 32'h1024, 64'h10, 64'h20, 1'b1, 5'd3, 64'h55, 1'b1, 1'b1, 5'd2, 5'd3,
                32'h0031_0233, 64'h10, 64'h55, 1'b1, 5'd4, 1'b0};                       // fwd port 2 only
    tbl[10] = '{32'h7FF0_0493, 32'h1028, 64'h99, 64'd0, 1'b1, 5'd0, 64'hEE, 1'b1, 1'b0, 5'd0, 5'd31,
                32'h7FF0_0493, 64'd0, 64'h7FF, 1'b1, 5'd9, 1'b0};                       // ADDI x9,x0,2047

    cycle(-1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(-1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(-1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_reset();

    // Back-to-back throughput over the table
    for (int i = 0; i < NV; i++) cycle(i, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(-1, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(-1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Stall for two cycles mid-stream: outputs hold, nothing lost or repeated
    cycle(0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(2, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(-1, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(-1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Flush while stalled, then flush while accepting
    cycle(3, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(4, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(5, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(-1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset while stalled, then reset while an accept would happen
    cycle(6, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(7, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(-1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_reset();
    cycle(8, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(-1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_reset();

    // Random handshake traffic
    for (int n = 0; n < 300; n++)
      cycle(int'($urandom_range(NV - 1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
            ($urandom_range(15) == 0), 1'b0);
    cycle(-1, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(-1, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
